// File: rtl/axi4_lite_port_arbiter.sv
// Two-requester arbiter sharing one axi4_lite_manager between the instruction-fetch
// and data load/store ports: zero-cycle grant, owner lock per transaction, round-robin on ties.
module axi4_lite_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction port (read-only)
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rd_data,
  output logic                  i_fault,
  output logic                  i_busy,
  // data port
  input  logic                  d_rd_en,
  input  logic                  d_wr_en,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wr_data,
  input  logic [3:0]            d_wr_strobe,
  output logic [31:0]           d_rd_data,
  output logic                  d_fault,
  output logic                  d_busy,
  // manager request interface
  output logic                  m_rd_en,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wr_data,
  output logic [3:0]            m_wr_strobe,
  input  logic [31:0]           m_rd_data,
  input  logic                  m_access_fault,
  input  logic                  m_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_e;

  owner_e owner;
  last_e  last;

  logic i_req;
  logic d_req;
  logic sel_i;
  logic sel_d;
  logic fwd;

  assign i_req = i_rd_en;
  assign d_req = d_rd_en | d_wr_en;

  // Port selection: the owner while locked, otherwise the same-cycle winner.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    unique case (owner)
      OWN_I: sel_i = 1'b1;
      OWN_D: sel_d = 1'b1;
      default: begin
        if (i_req && d_req) begin
          sel_d = (last == LAST_I);
          sel_i = (last == LAST_D);
        end else begin
          sel_i = i_req;
          sel_d = d_req;
        end
      end
    endcase
  end

  // Manager request mux; write takes precedence over a simultaneous data read.
  always_comb begin
    m_rd_en     = 1'b0;
    m_wr_en     = 1'b0;
    m_addr      = '0;
    m_wr_data   = '0;
    m_wr_strobe = '0;
    if (rst_n) begin
      if (sel_i) begin
        m_rd_en = i_rd_en;
        m_addr  = i_addr;
      end else if (sel_d) begin
        m_rd_en     = d_rd_en & ~d_wr_en;
        m_wr_en     = d_wr_en;
        m_addr      = d_addr;
        m_wr_data   = d_wr_data;
        m_wr_strobe = d_wr_strobe;
      end
    end
  end

  // Response routing: selected port sees the manager, the other port is stalled.
  always_comb begin
    i_rd_data = '0;
    i_fault   = 1'b0;
    i_busy    = 1'b0;
    d_rd_data = '0;
    d_fault   = 1'b0;
    d_busy    = 1'b0;
    if (rst_n) begin
      if (sel_i) begin
        i_rd_data = m_rd_data;
        i_fault   = m_access_fault;
        i_busy    = m_busy;
      end else begin
        i_busy = i_req;
      end
      if (sel_d) begin
        d_rd_data = m_rd_data;
        d_fault   = m_access_fault;
        d_busy    = m_busy;
      end else begin
        d_busy = d_req;
      end
    end
  end

  assign fwd = m_rd_en | m_wr_en;

  // Ownership and round-robin priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= IDLE;
      last  <= LAST_I;
    end else begin
      unique case (owner)
        OWN_I: begin
          if (!m_busy) begin
            owner <= IDLE;
            last  <= LAST_I;
          end
        end
        OWN_D: begin
          if (!m_busy) begin
            owner <= IDLE;
            last  <= LAST_D;
          end
        end
        default: begin
          if (fwd) begin
            if (m_busy) begin
              owner <= sel_d ? OWN_D : OWN_I;
            end else begin
              last <= sel_d ? LAST_D : LAST_I;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_port_arbiter.sv
// Directed bench for axi4_lite_port_arbiter: cycle table plus round-robin and
// mid-transaction reset sequences, manager responses driven directly.
module tb_axi4_lite_port_arbiter;

  localparam int unsigned AW = 32;
  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h0000_0200;
  localparam logic [31:0] WD = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rd_en;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rd_data;
  logic          i_fault;
  logic          i_busy;
  logic          d_rd_en;
  logic          d_wr_en;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wr_data;
  logic [3:0]    d_wr_strobe;
  logic [31:0]   d_rd_data;
  logic          d_fault;
  logic          d_busy;
  logic          m_rd_en;
  logic          m_wr_en;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wr_data;
  logic [3:0]    m_wr_strobe;
  logic [31:0]   m_rd_data;
  logic          m_access_fault;
  logic          m_busy;

  always #5 clk = ~clk;

  axi4_lite_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_fault(i_fault), .i_busy(i_busy),
    .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_wr_strobe(d_wr_strobe), .d_rd_data(d_rd_data), .d_fault(d_fault), .d_busy(d_busy),
    .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_wr_strobe(m_wr_strobe), .m_rd_data(m_rd_data), .m_access_fault(m_access_fault),
    .m_busy(m_busy)
  );

  typedef struct {
    logic        rst_n, ird, drd, dwr, mfault, mbusy;
    logic [31:0] iaddr, daddr, wdata, mrdata;
    logic [3:0]  strb;
    logic        e_mrd, e_mwr, e_ifault, e_ibusy, e_dfault, e_dbusy;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
    logic [3:0]  e_mstrb;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic r, input logic ird, input logic [31:0] iaddr,
    input logic drd, input logic dwr, input logic [31:0] daddr,
    input logic [31:0] wdata, input logic [3:0] strb,
    input logic [31:0] mrdata, input logic mfault, input logic mbusy,
    input logic emrd, input logic emwr, input logic [31:0] emaddr,
    input logic [31:0] emwdata, input logic [3:0] emstrb,
    input logic [31:0] eirdata, input logic eifault, input logic eibusy,
    input logic [31:0] edrdata, input logic edfault, input logic edbusy);
    vec_t v;
    v.rst_n = r; v.ird = ird; v.iaddr = iaddr; v.drd = drd; v.dwr = dwr; v.daddr = daddr;
    v.wdata = wdata; v.strb = strb; v.mrdata = mrdata; v.mfault = mfault; v.mbusy = mbusy;
    v.e_mrd = emrd; v.e_mwr = emwr; v.e_maddr = emaddr; v.e_mwdata = emwdata; v.e_mstrb = emstrb;
    v.e_irdata = eirdata; v.e_ifault = eifault; v.e_ibusy = eibusy;
    v.e_drdata = edrdata; v.e_dfault = edfault; v.e_dbusy = edbusy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; i_rd_en = v.ird; i_addr = v.iaddr; d_rd_en = v.drd; d_wr_en = v.dwr;
    d_addr = v.daddr; d_wr_data = v.wdata; d_wr_strobe = v.strb;
    m_rd_data = v.mrdata; m_access_fault = v.mfault; m_busy = v.mbusy;
  endtask

  task automatic compare(input int k, input vec_t v);
    string p;
    p = $sformatf("vec%0d", k);
    check({p, ".m_rd_en"},     32'(m_rd_en),     32'(v.e_mrd));
    check({p, ".m_wr_en"},     32'(m_wr_en),     32'(v.e_mwr));
    check({p, ".m_addr"},      m_addr,           v.e_maddr);
    check({p, ".m_wr_data"},   m_wr_data,        v.e_mwdata);
    check({p, ".m_wr_strobe"}, 32'(m_wr_strobe), 32'(v.e_mstrb));
    check({p, ".i_rd_data"},   i_rd_data,        v.e_irdata);
    check({p, ".i_fault"},     32'(i_fault),     32'(v.e_ifault));
    check({p, ".i_busy"},      32'(i_busy),      32'(v.e_ibusy));
    check({p, ".d_rd_data"},   d_rd_data,        v.e_drdata);
    check({p, ".d_fault"},     32'(d_fault),     32'(v.e_dfault));
    check({p, ".d_busy"},      32'(d_busy),      32'(v.e_dbusy));
  endtask

  initial begin
    rst_n = 1'b0; i_rd_en = 1'b0; i_addr = '0; d_rd_en = 1'b0; d_wr_en = 1'b0; d_addr = '0;
    d_wr_data = '0; d_wr_strobe = '0; m_rd_data = '0; m_access_fault = 1'b0; m_busy = 1'b0;

    //          rst ird iaddr drd dwr daddr  wdata  strb mrdata        mf mb | mrd mwr maddr mwdata strb irdata        if ib  drdata        df db
    // reset held with both requesting, then D wins the first tie
    vecs.push_back(mk(0, 1, IA, 0, 1, DA, WD, 4'hF, 32'hAAAA5555, 1, 1,  0, 0, 0,  0,  4'h0, 0,            0, 0, 0,            0, 0));
    vecs.push_back(mk(1, 1, IA, 0, 1, DA, WD, 4'hF, 32'h0,        0, 1,  0, 1, DA, WD, 4'hF, 0,            0, 1, 0,            0, 1));
    vecs.push_back(mk(1, 1, IA, 0, 1, DA, WD, 4'hF, 32'h0,        0, 0,  0, 1, DA, WD, 4'hF, 0,            0, 1, 0,            0, 0));
    // single I read, manager busy three cycles
    vecs.push_back(mk(1, 1, IA, 0, 0, DA, WD, 4'hF, 32'h0,        0, 1,  1, 0, IA, 0,  4'h0, 0,            0, 1, 0,            0, 0));
    vecs.push_back(mk(1, 1, IA, 0, 0, DA, WD, 4'hF, 32'h0,        0, 1,  1, 0, IA, 0,  4'h0, 0,            0, 1, 0,            0, 0));
    vecs.push_back(mk(1, 1, IA, 0, 0, DA, WD, 4'hF, 32'h0,        0, 1,  1, 0, IA, 0,  4'h0, 0,            0, 1, 0,            0, 0));
    vecs.push_back(mk(1, 1, IA, 0, 0, DA, WD, 4'hF, 32'hDEADBEEF, 0, 0,  1, 0, IA, 0,  4'h0, 32'hDEADBEEF, 0, 0, 0,            0, 0));
    // D store, I arrives mid-transaction and is stalled, then handed off
    vecs.push_back(mk(1, 0, IA, 0, 1, DA, WD, 4'hF, 32'h0,        0, 1,  0, 1, DA, WD, 4'hF, 0,            0, 0, 0,            0, 1));
    vecs.push_back(mk(1, 1, IA, 0, 1, DA, WD, 4'hF, 32'h0,        0, 1,  0, 1, DA, WD, 4'hF, 0,            0, 1, 0,            0, 1));
    vecs.push_back(mk(1, 1, IA, 0, 1, DA, WD, 4'hF, 32'h11111111, 0, 0,  0, 1, DA, WD, 4'hF, 0,            0, 1, 32'h11111111, 0, 0));
    vecs.push_back(mk(1, 1, IA, 0, 0, DA, WD, 4'hF, 32'h0,        0, 1,  1, 0, IA, 0,  4'h0, 0,            0, 1, 0,            0, 0));
    // fault on the I completion
    vecs.push_back(mk(1, 1, IA, 0, 0, DA, WD, 4'hF, 32'hCAFEF00D, 1, 0,  1, 0, IA, 0,  4'h0, 32'hCAFEF00D, 1, 0, 0,            0, 0));
    // following D read is clean, same-cycle completion
    vecs.push_back(mk(1, 0, IA, 1, 0, 32'h300, WD, 4'hF, 32'h0BADC0DE, 0, 0, 1, 0, 32'h300, WD, 4'hF, 0,  0, 0, 32'h0BADC0DE, 0, 0));
    // read and write together: write only
    vecs.push_back(mk(1, 0, IA, 1, 1, DA, WD, 4'h3, 32'h0,        0, 0,  0, 1, DA, WD, 4'h3, 0,            0, 0, 0,            0, 0));
    // idle: nothing forwarded, nothing routed
    vecs.push_back(mk(1, 0, IA, 0, 0, DA, WD, 4'hF, 32'h00000055, 1, 1,  0, 0, 0,  0,  4'h0, 0,            0, 0, 0,            0, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      compare(k, vecs[k]);
    end

    // round-robin under continuous contention, two-cycle transactions
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    i_rd_en = 1'b1; i_addr = IA; d_rd_en = 1'b0; d_wr_en = 1'b1; d_addr = DA;
    d_wr_data = WD; d_wr_strobe = 4'hF; m_access_fault = 1'b0; m_rd_data = '0;
    for (int t = 0; t < 6; t++) begin
      logic exp_d;
      exp_d = (t % 2 == 0);
      m_busy = 1'b1;
      #1;
      check($sformatf("rr%0d.grant_d", t), 32'(m_wr_en), 32'(exp_d));
      check($sformatf("rr%0d.grant_i", t), 32'(m_rd_en), 32'(!exp_d));
      check($sformatf("rr%0d.m_addr", t), m_addr, exp_d ? DA : IA);
      @(negedge clk);
      m_busy = 1'b0;
      #1;
      check($sformatf("rr%0d.i_busy", t), 32'(i_busy), 32'(exp_d));
      check($sformatf("rr%0d.d_busy", t), 32'(d_busy), 32'(!exp_d));
      @(negedge clk);
    end

    // reset while D owns the manager
    i_rd_en = 1'b0; d_wr_en = 1'b1; m_busy = 1'b1;
    #1;
    check("mid.grant_d", 32'(m_wr_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.rst_m_wr_en", 32'(m_wr_en), 32'd0);
    check("mid.rst_d_busy", 32'(d_busy), 32'd0);
    check("mid.rst_m_addr", m_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; d_wr_en = 1'b0; i_rd_en = 1'b1;
    #1;
    check("mid.i_m_rd_en", 32'(m_rd_en), 32'd1);
    check("mid.i_m_addr", m_addr, IA);
    check("mid.i_busy", 32'(i_busy), 32'd1);
    check("mid.m_wr_en", 32'(m_wr_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
